// File: rtl/exec_unit.sv
// exec_unit: multi-cycle execute unit (register file, ALU, PSR flags)
// Ports: clk, reset (async, active-high); in_valid/in_ready/instr accept one
// instruction per handshake; done/err pulse on retire; result holds the last
// ALU value; flags = PSR {N,Z,F,L,C}; dbg_addr/dbg_data peek a register.
module exec_unit #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        instr,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   result,
  output logic [4:0]         flags,
  input  logic [REGBITS-1:0] dbg_addr,
  output logic [WIDTH-1:0]   dbg_data
);
  localparam int NREG = 2**REGBITS;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] regs [NREG];
  logic [15:0] ir;
  logic [3:0] op, ox, code;
  logic [REGBITS-1:0] rd, rs;
  logic [WIDTH-1:0] a, b, alu, sh_v, res_n, res_q;
  logic [WIDTH:0] sum, dif;
  logic [4:0] sh, fl_n, fl_q;
  logic [5:0] mag;
  logic ok, sx, is_lsh, add_v, sub_v, lt_s, we_n, we_q, err_n, err_q;
  assign op = ir[15:12];
  assign ox = ir[7:4];
  assign rd = ir[8 +: REGBITS];
  assign rs = ir[0 +: REGBITS];
  // register-type ops carry their code in opext; immediates reuse it as opcode
  assign code = op == 4'h0 ? ox : op;
  assign ok = code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
  assign sx = code inside {4'h5, 4'h9, 4'hB, 4'hD};
  assign is_lsh = op == 4'h8 && ox == 4'h4;
  assign a = regs[rd];
  assign b = op == 4'h0 ? regs[rs] : sx ? WIDTH'($signed(ir[7:0])) : WIDTH'(ir[7:0]);
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign add_v = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
  assign sub_v = a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
  assign lt_s = $signed(a) < $signed(b);
  // shift amount is a signed 5-bit field: negative values shift right
  assign sh = regs[rs][4:0];
  assign mag = sh[4] ? 6'd32 - {1'b0, sh} : {1'b0, sh};
  assign sh_v = int'(mag) >= WIDTH ? '0 : sh[4] ? a >> mag : a << mag;
  assign alu = code == 4'h5 ? sum[WIDTH-1:0] :
               code == 4'h9 || code == 4'hB ? dif[WIDTH-1:0] :
               code == 4'h1 ? a & b :
               code == 4'h2 ? a | b :
               code == 4'h3 ? a ^ b : b;
  assign in_ready = state == IDLE;
  assign dbg_data = regs[dbg_addr];
  always_comb begin
    state_n = state == IDLE ? (in_valid ? EXEC : IDLE) : state == EXEC ? WB : IDLE;
    res_n = is_lsh ? sh_v : ok ? alu : result;
    we_n = is_lsh || (ok && code != 4'hB);
    err_n = !is_lsh && !ok;
    fl_n = flags;
    if (ok && code == 4'h5) fl_n = {flags[4:3], add_v, flags[1], sum[WIDTH]};
    if (ok && code == 4'h9) fl_n = {flags[4:3], sub_v, flags[1], dif[WIDTH]};
    if (ok && code == 4'hB) fl_n = {lt_s, a == b, flags[2], dif[WIDTH], flags[0]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ir <= '0;
      res_q <= '0;
      fl_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      result <= '0;
      flags <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      done <= state == WB;
      err <= state == WB && err_q;
      if (state == IDLE && in_valid) ir <= instr;
      if (state == EXEC) begin
        res_q <= res_n;
        fl_q <= fl_n;
        we_q <= we_n;
        err_q <= err_n;
      end
      if (state == WB) begin
        result <= res_q;
        flags <= fl_q;
        if (we_q) regs[rd] <= res_q;
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed and randomized checks of exec_unit against an arithmetic model
module tb_exec_unit;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic in_ready, done, err;
  logic [15:0] instr = '0, result, dbg_data;
  logic [4:0] flags;
  logic [3:0] dbg_addr = '0;
  int n_cmp = 0, n_bad = 0;
  int m_r [16];
  int m_res;
  bit mn, mz, mf, ml, mc;
  logic [3:0] vc [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};

  exec_unit #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .done(done), .err(err), .result(result), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sg(int x);
    return x >= 32768 ? x - 65536 : x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_r[k] = 0;
    m_res = 0;
    {mn, mz, mf, ml, mc} = '0;
  endtask

  task automatic model(input logic [15:0] i, output bit e);
    int op, ox, rd, rs, code, a, b, v, am, imm, s;
    bit wr;
    op = int'(i[15:12]); ox = int'(i[7:4]); rd = int'(i[11:8]); rs = int'(i[3:0]);
    imm = int'(i[7:0]);
    code = op == 0 ? ox : op;
    a = m_r[rd];
    b = op == 0 ? m_r[rs] : (code >= 1 && code <= 3) ? imm : (imm >= 128 ? imm + 65280 : imm);
    e = 0; wr = 1; v = 0;
    if (op == 8 && ox == 4) begin
      am = m_r[rs] % 32;
      if (am >= 16) am -= 32;
      v = am >= 0 ? (a << am) % 65536 : am <= -16 ? 0 : a >> (-am);
    end else if (code == 5) begin
      v = (a + b) % 65536; mc = a + b > 65535;
      s = sg(a) + sg(b); mf = s > 32767 || s < -32768;
    end else if (code == 9) begin
      v = (a - b + 65536) % 65536; mc = a < b;
      s = sg(a) - sg(b); mf = s > 32767 || s < -32768;
    end else if (code == 11) begin
      v = (a - b + 65536) % 65536; wr = 0;
      mz = a == b; mn = sg(a) < sg(b); ml = a < b;
    end else if (code == 1) v = a & b;
    else if (code == 2) v = a | b;
    else if (code == 3) v = a ^ b;
    else if (code == 13) v = b;
    else begin e = 1; wr = 0; end
    if (!e) m_res = v;
    if (wr) m_r[rd] = v;
  endtask

  // in_valid stays high through EXEC/WB so busy-cycle offers must be ignored
  task automatic run(input logic [15:0] i);
    bit e;
    @(negedge clk);
    check("ready_before", in_ready, 1);
    in_valid = 1'b1; instr = i;
    @(posedge clk); #1;
    check("exec_busy", {in_ready, done}, 0);
    @(posedge clk); #1;
    check("wb_busy", {in_ready, done}, 0);
    @(posedge clk); #1;
    model(i, e);
    check($sformatf("retire_%h", i), {in_ready, done, err}, {2'b11, e});
    check($sformatf("result_%h", i), result, m_res);
    check($sformatf("flags_%h", i), flags, {mn, mz, mf, ml, mc});
    dbg_addr = i[11:8]; #1;
    check($sformatf("rd_%h", i), dbg_data, m_r[i[11:8]]);
    dbg_addr = 4'($urandom); #1;
    check("rand_reg", dbg_data, m_r[dbg_addr]);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", {done, err}, 0);
  endtask

  task automatic peek(input string tag, input logic [3:0] r, input logic [15:0] exp);
    dbg_addr = r; #1;
    check(tag, dbg_data, exp);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] i;
    i = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: begin i[15:12] = 4'h0; if ($urandom_range(0, 4) != 0) i[7:4] = vc[$urandom_range(0, 6)]; end
      3: begin i[15:12] = 4'h8; if ($urandom_range(0, 3) != 0) i[7:4] = 4'h4; end
      9: ;
      default: i[15:12] = vc[$urandom_range(0, 6)];
    endcase
    return i;
  endfunction

  initial begin
    model_reset();
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_pulse", {done, err}, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) peek("rst_reg", 4'(k), 16'h0);
    run(16'hD17F);
    peek("movi_r1", 4'd1, 16'h007F);
    check("movi_flags", flags, 0);
    run(16'hD908); run(16'h8149); run(16'h21FF); run(16'hD201);
    peek("r1_7fff", 4'd1, 16'h7FFF);
    run(16'h0152);
    peek("add_r1", 4'd1, 16'h8000);
    check("add_fc", {flags[2], flags[0]}, 2'b10);
    run(16'hD300); run(16'h53FF);
    peek("addi_r3", 4'd3, 16'hFFFF);
    check("addi_c", flags[0], 0);
    run(16'hD403); run(16'hD5FE); run(16'h04B5);
    peek("cmp_nowrite", 4'd4, 16'h0003);
    check("cmp_nzl", {flags[4], flags[3], flags[1]}, 3'b001);
    check("cmp_result", result, 16'h0005);
    run(16'hD600); run(16'h26F0); run(16'hD7FC); run(16'h8647);
    peek("lsh_right", 4'd6, 16'h000F);
    run(16'hD710); run(16'h8647);
    peek("lsh_16", 4'd6, 16'h0000);
    run(16'hF000);
    check("undef_result", result, 16'h0000);
    run(16'hD8FF);
    @(negedge clk);
    in_valid = 1'b1; instr = 16'h18F0;
    @(posedge clk); #2;
    reset = 1'b1; in_valid = 1'b0; #1;
    check("midrst_ready", in_ready, 1);
    check("midrst_done", done, 0);
    peek("midrst_r8", 4'd8, 16'h0000);
    @(negedge clk); reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("midrst_nodone", done, 0);
    end
    run(16'hD8FF); run(16'h18F0);
    peek("andi_r8", 4'd8, 16'h00F0);
    for (int n = 0; n < 300; n++) run(rand_instr());
    for (int k = 0; k < 16; k++) peek("final_reg", 4'(k), 16'(m_r[k]));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised multi-cycle execute unit: the successor to the 16-bit regfile/ALU datapath top. Accepts one instruction word per handshake, reads two operands from an internal register file, executes in the ALU, writes back, and updates a processor status register (PSR). Sits between the future fetch/decode stage and the register file. Unlike the previous datapath it sequences its own read/execute/write-back, supports immediates and comparisons, and keeps flags.

## Interface
- WIDTH, 16, datapath and register width (≥ 8)
- REGBITS, 4, register address bits; 2**REGBITS registers
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept; equals (state==IDLE)
- instr  in  16  {opcode[15:12], rdest[11:8], opext[7:4], rsrc_imm[3:0]}; rdest/rsrc use low REGBITS bits
- done  out  1  one-cycle pulse: instruction retired
- err  out  1  one-cycle pulse with done: undefined opcode/opext
- result  out  WIDTH  last ALU result, held until the next retire
- flags  out  5  PSR {N, Z, F, L, C}
- dbg_addr  in  REGBITS  debug read address
- dbg_data  out  WIDTH  combinational read of register dbg_addr

## Operation
- FSM states: IDLE → EXEC → WB → IDLE. Transfer when in_valid & in_ready in IDLE; instr latched into IR.
- EXEC: read R[rdest], R[rsrc]; form operand B; compute ALU result and candidate flags into pipeline registers.
- WB: write R[rdest] if the op writes; commit flags if the op sets them; pulse done; update result.
- Register-type (opcode 0000), B = R[rsrc]; opext: 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV.
- Immediate-type, opcode = same code as the register opext (0101 ADDI, 1001 SUBI, 1011 CMPI, 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI); imm8 = {opext, rsrc_imm}. Sign-extended to WIDTH for ADDI/SUBI/CMPI/MOVI; zero-extended for ANDI/ORI/XORI.
- Shift: opcode 1000, opext 0100 = LSH. R[rdest] shifted logically by signed R[rsrc][4:0]: positive = left, negative = right; |amount| ≥ WIDTH gives 0.
- Arithmetic is modulo 2**WIDTH. ADD: C = carry out, F = signed overflow. SUB (A−B): C = borrow (A<B unsigned), F = signed overflow. Other flags unchanged.
- CMP/CMPI: no write; Z = (A==B), N = (A<B signed), L = (A<B unsigned); C, F unchanged. result = A−B.
- Logic, MOV, LSH: write only; flags unchanged.
- Any other opcode/opext: no write, flags unchanged, result unchanged, done and err pulse in WB.
- rdest == rsrc: operand read before write, so the old value is used.
- dbg_data reflects a write from the cycle after the WB edge.

## Timing
- Reset (asynchronous, immediate): state IDLE, all registers 0, flags 0, result 0, done 0, err 0, IR 0; in_ready = 1 from reset deassertion.
- Accept edge t. EXEC covers t..t+1 and WB covers t+1..t+2. done/err high in cycle t+2 (after edge t+2), along with the new result, register and flags. in_ready returns high at t+2.
- Throughput: one instruction per 3 cycles. A back-to-back dependent instruction sees the written value with no hazard.
- in_valid while in_ready = 0: ignored, not queued. The source must hold instr until in_ready.
- Reset during EXEC/WB: instruction dropped, nothing written, no done.

## Test plan
- Reset, then MOVI R1,#0x7F (0xD17F): done at t+2; R1 = 0x007F; flags = 0.
- R1 = 0x7FFF, R2 = 0x0001, ADD R1,R2 (0x0152): R1 = 0x8000, F = 1, C = 0. Then ADDI R3,#−1 with R3 = 0 (0x53FF): R3 = 0xFFFF, C = 0.
- R4 = 0x0003, R5 = 0xFFFE, CMP R4,R5 (0x04B5): no write, Z = 0, N = 0, L = 1; result = 0x0005.
- R6 = 0x00F0, LSH R6 by R7 = 0xFFFC (−4) (0x8647): R6 = 0x000F. With R7 = 16: R6 = 0.
- Undefined opcode 0xF000: done and err pulse together; registers, flags and result unchanged. in_valid held high during EXEC: exactly one accept per 3 cycles.
- ANDI R8,#0xF0 with R8 = 0xFFFF (0x18F0) followed by assertion of reset in EXEC: R8 stays 0 after reset, no done; the next accept works normally.
